// File: rtl/hex_rate_counter_if.sv
// Control and display-digit bundle between a rate-counter driver and the counter.
// Latency: none (wires only); the counter registers every output it drives.
// Backpressure: none; the counter samples its inputs on every rising clock edge.
interface hex_rate_counter_if;
  logic       enable;
  logic [1:0] speed;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       tick;
  logic       wrap;

  // Driver side: issues controls, observes the digit and its pulses
  modport master (
    output enable, speed, load, load_value,
    input  count, tick, wrap
  );

  // Counter side: consumes controls, produces the digit and its pulses
  modport slave (
    input  enable, speed, load, load_value,
    output count, tick, wrap
  );
endinterface

// File: rtl/hex_rate_counter.sv
// Rate-divided 0-F hex counter feeding the seven-segment decoder, with tick/wrap pulses.
// Latency: all outputs registered; an increment appears P enabled cycles after the last reload.
// Backpressure: none; enable=0 freezes divider and count. Define HEX_RATE_SIM_EN for 4/8/16-cycle periods.
module hex_rate_counter #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic          clock,
  input  logic          reset,
  hex_rate_counter_if.slave bus
);

`ifdef HEX_RATE_SIM_EN
  // Short periods so a simulation sees many increments in a few hundred cycles
  localparam int DW = 5;
  localparam int P1 = 4;
  localparam int P2 = 8;
  localparam int P3 = 16;
`else
  // 28 bits holds 4 * 50e6 - 1, the longest reload value at the board clock
  localparam int DW = 28;
  localparam int P1 = CLK_FREQ;
  localparam int P2 = 2 * CLK_FREQ;
  localparam int P3 = 4 * CLK_FREQ;
`endif

  localparam logic [DW-1:0] RELOAD1 = DW'(P1 - 1);
  localparam logic [DW-1:0] RELOAD2 = DW'(P2 - 1);
  localparam logic [DW-1:0] RELOAD3 = DW'(P3 - 1);

  logic [3:0]    count_q, count_d;
  logic          tick_q,  tick_d;
  logic          wrap_q,  wrap_d;
  logic [DW-1:0] div_q,   div_d;
  logic [1:0]    speed_q, speed_d;

  // Divider reload value (P-1); speed 00 reloads to 0 so every enabled cycle expires
  function automatic logic [DW-1:0] reload_for(input logic [1:0] s);
    logic [DW-1:0] r;
    case (s)
      2'b01:   r = RELOAD1;
      2'b10:   r = RELOAD2;
      2'b11:   r = RELOAD3;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next-state: load beats a speed change, which beats normal enabled counting
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    div_d   = div_q;
    speed_d = speed_q;
    if (bus.load) begin
      // A load restarts the period at the stored rate; a pending speed change is seen next cycle
      count_d = bus.load_value;
      div_d   = reload_for(speed_q);
    end else if (bus.speed != speed_q) begin
      // Partial period at the old rate is discarded
      speed_d = bus.speed;
      div_d   = reload_for(bus.speed);
    end else if (bus.enable) begin
      if (div_q == '0) begin
        div_d   = reload_for(speed_q);
        count_d = count_q + 4'd1;
        tick_d  = 1'b1;
        wrap_d  = (count_q == 4'hF);
      end else begin
        div_d = div_q - DW'(1);
      end
    end
  end

  // State registers; reset primes the divider for whichever speed is selected right now
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      div_q   <= reload_for(bus.speed);
      speed_q <= bus.speed;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
      speed_q <= speed_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/hex_rate_counter.md
# hex_rate_counter

Rate-divided 4-bit hexadecimal counter that generates the nibble driven into the seven-segment hex decoder stage. It divides the 50 MHz board clock down to a switch-selected rate, advances a 0–F count at that rate, and emits single-cycle tick and wrap pulses. Output `count` connects directly to the decoder's 4-bit `SW` input; the decoder's `HEX0` drives the display.

## Interface
- `CLK_FREQ`, 50000000, clock cycles per second; sets the 1 Hz divider period.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count enable; low freezes divider and count.
- `speed`  in  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
- `load`  in  1  synchronous parallel load of `load_value`.
- `load_value`  in  4  value loaded into `count`.
- `count`  out  4  current hex digit, registered; feeds the hex decoder.
- `tick`  out  1  one-cycle pulse in the cycle `count` shows an incremented value.
- `wrap`  out  1  one-cycle pulse when `count` goes F→0 by increment.

## Operation
- Period P by `speed`: 00→1, 01→CLK_FREQ, 10→2·CLK_FREQ, 11→4·CLK_FREQ. Divider is a 28-bit down counter, which is sufficient for 4·50e6.
- Reset: `count`=0, `tick`=0, `wrap`=0, divider=P−1 for the current `speed`, stored speed=`speed`.
- Priority per cycle, highest first: reset, load, speed change, enable.
- Load (`load`=1): `count`←`load_value`, divider←P−1, `tick`=`wrap`=0. `enable` is ignored.
- Speed change (stored speed ≠ `speed`, no load): divider←P−1 for the new speed, stored speed updated, `count` held, pulses 0.
- Enabled, divider≠0: divider←divider−1, pulses 0.
- Enabled, divider=0: divider←P−1, `count`←`count`+1 modulo 16, `tick`←1. `wrap`←1 only if the old `count`=F.
- `enable`=0: divider and `count` hold, pulses 0.
- Speed 00: divider is always 0, so `count` increments on every enabled cycle and `tick` stays high continuously.
- Arithmetic: `count` is 4-bit unsigned and wraps naturally. The divider never underflows because it is reloaded at 0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- With `enable` held high from the first edge after reset deasserts, the first increment appears on the P-th rising edge. `count` shows 1, and `tick` is high for that one cycle.
- Subsequent increments occur every P enabled cycles. Disabled cycles stretch the interval one-for-one.
- `tick` and `wrap` are asserted in the same cycle as the new `count` value.
- Reset mid-period discards the partial divider count; the next increment is a full P cycles after reset.
- Load on the same edge the divider would expire: load wins, and no `tick` is produced.

## Configuration
- `HEX_RATE_SIM_EN`: when defined, the 01/10/11 periods are 4/8/16 cycles and the divider shrinks to 5 bits, for simulation.
- When undefined, periods are derived from `CLK_FREQ` as above. Speed 00 is unaffected either way.

## Test plan
- With `HEX_RATE_SIM_EN` defined: reset, then `speed`=01 and `enable`=1 for 20 cycles → `count` = 1,2,3,4 at edges 4,8,12,16 after reset. `tick` is high exactly on those cycles.
- `speed`=00, `enable`=1, start from reset → `count` increments every cycle. `wrap` pulses on the F→0 cycle, 16 cycles after reset.
- At `count`=5 mid-period, drop `enable` for 10 cycles → `count` holds 5. The next increment arrives after the remaining divider cycles plus 10.
- `load`=1, `load_value`=E, on the expiry cycle → `count`=E and `tick`=0. After 8 more enabled cycles at `speed`=01: `count`=F, then 0 with `wrap`=1.
- Change `speed` 11→01 with the divider at 9 → divider reloads to 3, and the next increment is 4 cycles later.
- Assert `reset` at `count`=A mid-period → next cycle `count`=0 and `tick`=`wrap`=0. The first increment comes a full P later.
